// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the 1-to-2 demultiplexer and its channel buffers.
package demux_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demux1t2_64_fifo_buf.sv
// Small synchronous FIFO with registered storage; head is zero whenever the buffer is empty.
module fifo_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [OW-1:0]    r_occ;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_occ == OW'(DEPTH));
  assign o_empty   = (r_occ == '0);
  // A full buffer refuses the push even if it is being popped this cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/demux1t2_64.sv
// Routes an input word stream into one of two buffered channels and counts words per channel.
module demux1t2_64
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             w_full0;
  logic             w_full1;
  logic             w_empty0;
  logic             w_empty1;
  logic             w_accept;
  logic             w_push0;
  logic             w_push1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Held low during reset so nothing is accepted while buffers are being cleared.
  assign i_ready  = rst_n & ~((chan_e'(i_sel) == CH1) ? w_full1 : w_full0);
  assign w_accept = i_valid & i_ready;
  assign w_push0  = w_accept & (chan_e'(i_sel) == CH0);
  assign w_push1  = w_accept & (chan_e'(i_sel) == CH1);

  assign o0_valid = ~w_empty0;
  assign o1_valid = ~w_empty1;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

  fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_data  (i_data),
    .i_pop   (o0_ready),
    .o_full  (w_full0),
    .o_empty (w_empty0),
    .o_head  (o0_data)
  );

  fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_data  (i_data),
    .i_pop   (o1_ready),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_head  (o1_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_push1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

endmodule
